// File: rtl/car_sim_pkg.sv
// Shared definitions for the car simulator front end.
// Key index constants map keypad legends to bit positions in every
// N_KEYS-wide key vector. The package also provides the key code width
// and the priority encoder used to derive key_code from the key levels.
package car_sim_pkg;

    localparam int N_KEYS     = 12;
    localparam int KEY_CODE_W = 4;

    localparam int KEY_IDX_1     = 0;
    localparam int KEY_IDX_2     = 1;
    localparam int KEY_IDX_3     = 2;
    localparam int KEY_IDX_4     = 3;
    localparam int KEY_IDX_5     = 4;
    localparam int KEY_IDX_6     = 5;
    localparam int KEY_IDX_7     = 6;
    localparam int KEY_IDX_8     = 7;
    localparam int KEY_IDX_9     = 8;
    localparam int KEY_IDX_STAR  = 9;
    localparam int KEY_IDX_0     = 10;
    localparam int KEY_IDX_SHARP = 11;

    typedef logic [N_KEYS-1:0]     key_vec_t;
    typedef logic [KEY_CODE_W-1:0] key_code_t;

    // Index of the lowest set bit; 0 when no bit is set (the caller
    // separates "key 1" from "none" with the valid flag).
    function automatic key_code_t prio_encode(input key_vec_t lv);
        key_code_t code;
        code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (lv[i]) code = KEY_CODE_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debouncer_if.sv
// Keypad conditioning bus.
// slave  : the debouncer side (takes tick_sample and key_raw, drives the
//          conditioned key outputs).
// master : the consumer/driver side (drives tick_sample and key_raw,
//          reads the conditioned outputs).
interface keypad_debouncer_if;
    import car_sim_pkg::*;

    logic      tick_sample;
    key_vec_t  key_raw;
    key_vec_t  key_level;
    key_vec_t  key_press;
    key_vec_t  key_release;
    key_vec_t  key_hold;
    logic      any_key;
    key_code_t key_code;
    logic      key_code_valid;

    modport slave (
        input  tick_sample, key_raw,
        output key_level, key_press, key_release, key_hold,
               any_key, key_code, key_code_valid
    );

    modport master (
        output tick_sample, key_raw,
        input  key_level, key_press, key_release, key_hold,
               any_key, key_code, key_code_valid
    );

endinterface

// File: rtl/key_debounce_cell.sv
// One key's conditioning chain: 2-flop synchroniser, tick-based debounce
// counter, hold counter and the registered level/press/release/hold
// outputs. key_level_nxt exposes the level the next clock edge will load,
// so the parent can register a key code in the same cycle as key_level.
// Optional macro KEYPAD_REPEAT_EN adds an auto-repeat counter that
// re-pulses key_press every REPEAT_TICKS ticks while key_hold is high.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick_sample     one-clk sampling strobe
//   key_raw         raw asynchronous key input
//   key_level       debounced level
//   key_level_nxt   combinational next value of key_level
//   key_press       one-clk pulse on debounced rise (and repeats)
//   key_release     one-clk pulse on debounced fall
//   key_hold        high while pressed for at least HOLD_TICKS ticks
module key_debounce_cell #(
    parameter int DEB_SAMPLES = 4,
    parameter int HOLD_TICKS  = 500
`ifdef KEYPAD_REPEAT_EN
    , parameter int REPEAT_TICKS = 100
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_sample,
    input  logic key_raw,
    output logic key_level,
    output logic key_level_nxt,
    output logic key_press,
    output logic key_release,
    output logic key_hold
);

    localparam int DEB_W  = $clog2(DEB_SAMPLES + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    logic              sync_p0, sync_p1;
    logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              press_nxt, release_nxt, hold_nxt;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
    logic [RPT_W-1:0]  rpt_cnt, rpt_cnt_nxt;
`endif

    // Stage p0/p1: two-flop synchroniser, runs every clock
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce, hold and repeat next-state on the synchronised level
    always_comb begin
        deb_cnt_nxt   = deb_cnt;
        key_level_nxt = key_level;
        if (tick_sample) begin
            if (sync_p1 != key_level) begin
                if (deb_cnt == DEB_W'(DEB_SAMPLES - 1)) begin
                    key_level_nxt = sync_p1;
                    deb_cnt_nxt   = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt_nxt = '0;
            end
        end

        press_nxt   = key_level_nxt & ~key_level;
        release_nxt = key_level & ~key_level_nxt;

        // Counting starts on the tick after the rise; the rise tick itself
        // sees key_level=0 and does not count.
        hold_cnt_nxt = hold_cnt;
        if (!key_level_nxt) begin
            hold_cnt_nxt = '0;
        end else if (tick_sample && key_level && hold_cnt != HOLD_W'(HOLD_TICKS)) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
        end
        hold_nxt = key_level_nxt && (hold_cnt_nxt == HOLD_W'(HOLD_TICKS));

`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_nxt = rpt_cnt;
        if (!key_level_nxt) begin
            rpt_cnt_nxt = '0;
        end else if (tick_sample && key_hold) begin
            if (rpt_cnt == RPT_W'(REPEAT_TICKS - 1)) begin
                rpt_cnt_nxt = '0;
                press_nxt   = 1'b1;
            end else begin
                rpt_cnt_nxt = rpt_cnt + 1'b1;
            end
        end
`endif
    end

    // Stage p2: registered level, counters and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_hold    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt     <= '0;
`endif
        end else begin
            deb_cnt     <= deb_cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            key_level   <= key_level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_hold    <= hold_nxt;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt     <= rpt_cnt_nxt;
`endif
        end
    end

endmodule

// File: rtl/keypad_debouncer.sv
// 12-key keypad front end: one key_debounce_cell per key plus a registered
// priority encoder producing key_code / key_code_valid / any_key in the
// same clock as the key_level update.
// Optional macro KEYPAD_REPEAT_EN enables per-key auto-repeat on key_press.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       keypad_debouncer_if.slave: tick_sample, key_raw in;
//             key_level, key_press, key_release, key_hold, any_key,
//             key_code, key_code_valid out
module keypad_debouncer
    import car_sim_pkg::*;
#(
    parameter int DEB_SAMPLES = 4,
    parameter int HOLD_TICKS  = 500
`ifdef KEYPAD_REPEAT_EN
    , parameter int REPEAT_TICKS = 100
`endif
) (
    input  logic               clk,
    input  logic               rst,
    keypad_debouncer_if.slave  bus
);

    key_vec_t  level_v, level_nxt_v, press_v, release_v, hold_v;
    key_code_t code_p2;
    logic      valid_p2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_cell
        key_debounce_cell #(
            .DEB_SAMPLES  (DEB_SAMPLES),
            .HOLD_TICKS   (HOLD_TICKS)
`ifdef KEYPAD_REPEAT_EN
            , .REPEAT_TICKS (REPEAT_TICKS)
`endif
        ) u_cell (
            .clk           (clk),
            .rst           (rst),
            .tick_sample   (bus.tick_sample),
            .key_raw       (bus.key_raw[i]),
            .key_level     (level_v[i]),
            .key_level_nxt (level_nxt_v[i]),
            .key_press     (press_v[i]),
            .key_release   (release_v[i]),
            .key_hold      (hold_v[i])
        );
    end

    // Stage p2: encode the next levels so code and level move together
    always_ff @(posedge clk) begin
        if (rst) begin
            code_p2  <= '0;
            valid_p2 <= 1'b0;
        end else begin
            code_p2  <= prio_encode(level_nxt_v);
            valid_p2 <= |level_nxt_v;
        end
    end

    assign bus.key_level      = level_v;
    assign bus.key_press      = press_v;
    assign bus.key_release    = release_v;
    assign bus.key_hold       = hold_v;
    assign bus.any_key        = valid_p2;
    assign bus.key_code       = code_p2;
    assign bus.key_code_valid = valid_p2;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer: a vector table for single-tick
// level/pulse/code behaviour plus hand sequences for hold, auto-repeat
// and reset in the middle of a debounce.
module tb_keypad_debouncer;
    import car_sim_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    keypad_debouncer_if bus();

    keypad_debouncer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] raw;
        int          ticks;
        logic [11:0] lvl;
        logic [11:0] prs;
        logic [11:0] rel;
        logic [11:0] hld;
        logic [3:0]  code;
        logic        vld;
    } vec_t;

    vec_t tbl[$];

    localparam logic [11:0] K0 = 12'h400;
    localparam logic [11:0] KS = 12'h200;
    localparam logic [11:0] K1 = 12'h001;
    localparam logic [11:0] K3 = 12'h004;
    localparam logic [11:0] K6 = 12'h020;
    localparam logic [11:0] K8 = 12'h080;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock with the given tick value; returns at the following negedge.
    task automatic cyc(input logic tk);
        bus.tick_sample = tk;
        @(posedge clk);
        @(negedge clk);
        bus.tick_sample = 1'b0;
    endtask

    // Three idle clocks (lets the synchroniser settle) then one tick clock.
    task automatic tick1();
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick1();
    endtask

    task automatic add(input logic [11:0] raw, input int t, input logic [11:0] lvl,
                       input logic [11:0] prs, input logic [11:0] rel, input logic [11:0] hld,
                       input logic [3:0] code, input logic vld);
        vec_t v;
        v.raw = raw; v.ticks = t; v.lvl = lvl; v.prs = prs; v.rel = rel;
        v.hld = hld; v.code = code; v.vld = vld;
        tbl.push_back(v);
    endtask

    int presses;
    int misplaced;
    int exp_rep;
    bit rep_en;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.tick_sample = 1'b0;
        bus.key_raw = '0;

`ifdef KEYPAD_REPEAT_EN
        rep_en = 1'b1;
`else
        rep_en = 1'b0;
`endif

        // clean press / release of key 0
        add(12'h000,  1, 12'h000, 12'h000, 12'h000, 12'h000, 4'd0,  1'b0);
        add(K0,       3, 12'h000, 12'h000, 12'h000, 12'h000, 4'd0,  1'b0);
        add(K0,       1, K0,      K0,      12'h000, 12'h000, 4'd10, 1'b1);
        add(K0,       1, K0,      12'h000, 12'h000, 12'h000, 4'd10, 1'b1);
        add(K0,      16, K0,      12'h000, 12'h000, 12'h000, 4'd10, 1'b1);
        add(12'h000,  3, K0,      12'h000, 12'h000, 12'h000, 4'd10, 1'b1);
        add(12'h000,  1, 12'h000, 12'h000, K0,      12'h000, 4'd0,  1'b0);
        // bouncing star key never settles
        for (int i = 0; i < 10; i++)
            add((i % 2 == 0) ? KS : 12'h000, 1, 12'h000, 12'h000, 12'h000, 12'h000, 4'd0, 1'b0);
        add(12'h000,  4, 12'h000, 12'h000, 12'h000, 12'h000, 4'd0,  1'b0);
        // simultaneous keys 3 and 8
        add(K3 | K8,  3, 12'h000, 12'h000, 12'h000, 12'h000, 4'd0,  1'b0);
        add(K3 | K8,  1, K3 | K8, K3 | K8, 12'h000, 12'h000, 4'd2,  1'b1);
        add(K8,       3, K3 | K8, 12'h000, 12'h000, 12'h000, 4'd2,  1'b1);
        add(K8,       1, K8,      12'h000, K3,      12'h000, 4'd7,  1'b1);
        add(12'h000,  3, K8,      12'h000, 12'h000, 12'h000, 4'd7,  1'b1);
        add(12'h000,  1, 12'h000, 12'h000, K8,      12'h000, 4'd0,  1'b0);

        // reset state
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("rst_level", bus.key_level, 0);
        check("rst_code",  {bus.key_code_valid, bus.any_key, bus.key_code}, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            bus.key_raw = tbl[i].raw;
            ticks(tbl[i].ticks);
            check($sformatf("v%0d_level", i),   bus.key_level,      tbl[i].lvl);
            check($sformatf("v%0d_press", i),   bus.key_press,      tbl[i].prs);
            check($sformatf("v%0d_release", i), bus.key_release,    tbl[i].rel);
            check($sformatf("v%0d_hold", i),    bus.key_hold,       tbl[i].hld);
            check($sformatf("v%0d_code", i),    bus.key_code,       tbl[i].code);
            check($sformatf("v%0d_valid", i),   bus.key_code_valid, tbl[i].vld);
            check($sformatf("v%0d_any", i),     bus.any_key,        tbl[i].vld);
            cyc(1'b0);
            check($sformatf("v%0d_idle_pulse", i), {bus.key_press, bus.key_release}, 0);
        end

        // hold and auto-repeat on key 3
        bus.key_raw = K3;
        ticks(4);
        check("hold_rise_level", bus.key_level, K3);
        check("hold_rise_press", bus.key_press, K3);
        ticks(499);
        check("hold_499", bus.key_hold, 0);
        tick1();
        check("hold_500", bus.key_hold, K3);
        presses = 0;
        misplaced = 0;
        for (int t = 501; t <= 700; t++) begin
            tick1();
            if (bus.key_press != 0) begin
                presses++;
                if (!(rep_en && (t == 600 || t == 700))) misplaced++;
            end
        end
        exp_rep = rep_en ? 2 : 0;
        check("repeat_count", presses, exp_rep);
        check("repeat_place", misplaced, 0);
        check("hold_700", bus.key_hold, K3);
        bus.key_raw = '0;
        ticks(3);
        check("rel3_level", bus.key_level, K3);
        check("rel3_hold",  bus.key_hold,  K3);
        tick1();
        check("rel4_level",   bus.key_level,   0);
        check("rel4_hold",    bus.key_hold,    0);
        check("rel4_release", bus.key_release, K3);
        check("rel4_press",   bus.key_press,   0);

        // reset in the middle of a debounce
        bus.key_raw = K6;
        ticks(4);
        check("pre_rst_level", bus.key_level, K6);
        bus.key_raw = K6 | K1;
        ticks(2);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        check("mid_rst_level", bus.key_level, 0);
        check("mid_rst_code",  {bus.key_code_valid, bus.any_key, bus.key_code}, 0);
        ticks(3);
        check("post_rst_3", bus.key_level, 0);
        tick1();
        check("post_rst_level", bus.key_level, K6 | K1);
        check("post_rst_press", bus.key_press, K6 | K1);
        check("post_rst_code",  {bus.key_code_valid, bus.key_code}, {1'b1, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
